// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the datapath and the sized data memory.
// The datapath drives requests through the master modport; the memory
// answers through the slave modport.
interface data_memory_sized_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] read_data;
    logic        read_valid;
    logic        misaligned;
    logic        out_of_range;

    modport master (
        output address, write_data, mem_write, mem_read, size, load_unsigned,
        input  read_data, read_valid, misaligned, out_of_range
    );

    modport slave (
        input  address, write_data, mem_write, mem_read, size, load_unsigned,
        output read_data, read_valid, misaligned, out_of_range
    );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressed, big-endian data memory with byte/half/word accesses,
// sign/zero-extended loads, a READ_LATENCY-deep read pipeline with a valid
// strobe, and one-cycle fault pulses for misaligned or out-of-range accesses.
module data_memory_sized #(
    parameter int MEM_WORDS    = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_memory_sized_if.slave    bus
);

    localparam int             MEM_BYTES = MEM_WORDS * 4;
    localparam int             IDX_W     = $clog2(MEM_BYTES);
    localparam logic [32:0]    LIMIT     = 33'(MEM_BYTES);

    logic [7:0]              r_mem [MEM_BYTES];

    logic [READ_LATENCY-1:0] r_valid;
    logic [31:0]             r_data [READ_LATENCY];
    logic                    r_misaligned;
    logic                    r_out_of_range;

    logic [32:0]             w_nbytes;
    logic [32:0]             w_last;
    logic                    w_misalign;
    logic                    w_range_bad;
    logic                    w_req;
    logic                    w_do_read;
    logic                    w_do_write;
    logic [IDX_W-1:0]        w_idx0;
    logic [IDX_W-1:0]        w_idx1;
    logic [IDX_W-1:0]        w_idx2;
    logic [IDX_W-1:0]        w_idx3;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_word;
    logic                    w_signed;
    logic [31:0]             w_load;

    // Access width in bytes; the reserved size is already a fault so its width is moot.
    always_comb begin
        w_nbytes = 33'd4;
        case (bus.size)
            2'b00:   w_nbytes = 33'd1;
            2'b01:   w_nbytes = 33'd2;
            default: w_nbytes = 33'd4;
        endcase
    end

    // The last touched byte is computed in 33 bits so addresses near 2^32 cannot wrap into range.
    assign w_last      = {1'b0, bus.address} + w_nbytes - 33'd1;
    assign w_range_bad = (w_last >= LIMIT);
    assign w_misalign  = (bus.size == 2'b11)
                       | ((bus.size == 2'b01) & bus.address[0])
                       | ((bus.size == 2'b10) & (|bus.address[1:0]));
    assign w_req       = bus.mem_read | bus.mem_write;
    assign w_do_read   = bus.mem_read & ~w_misalign & ~w_range_bad;
    assign w_do_write  = bus.mem_write & ~bus.mem_read & ~w_misalign & ~w_range_bad;

    assign w_idx0 = bus.address[IDX_W-1:0];
    assign w_idx1 = w_idx0 + IDX_W'(1);
    assign w_idx2 = w_idx0 + IDX_W'(2);
    assign w_idx3 = w_idx0 + IDX_W'(3);

    // Big-endian fetch and extension; the lowest address supplies the most significant byte.
    always_comb begin
        w_byte   = r_mem[w_idx0];
        w_half   = {r_mem[w_idx0], r_mem[w_idx1]};
        w_word   = {r_mem[w_idx0], r_mem[w_idx1], r_mem[w_idx2], r_mem[w_idx3]};
        w_signed = ~bus.load_unsigned;
        w_load   = w_word;
        case (bus.size)
            2'b00:   w_load = {{24{w_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{w_signed & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Store path: only the bytes covered by the access are updated; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            case (bus.size)
                2'b00: begin
                    r_mem[w_idx0] <= bus.write_data[7:0];
                end
                2'b01: begin
                    r_mem[w_idx0] <= bus.write_data[15:8];
                    r_mem[w_idx1] <= bus.write_data[7:0];
                end
                default: begin
                    r_mem[w_idx0] <= bus.write_data[31:24];
                    r_mem[w_idx1] <= bus.write_data[23:16];
                    r_mem[w_idx2] <= bus.write_data[15:8];
                    r_mem[w_idx3] <= bus.write_data[7:0];
                end
            endcase
        end
    end

    // Read pipeline and fault pulses; each data stage only advances behind a valid so the output holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= '0;
            r_misaligned   <= 1'b0;
            r_out_of_range <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= w_do_read;
            if (w_do_read) begin
                r_data[0] <= w_load;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
            r_misaligned   <= w_req & w_misalign;
            r_out_of_range <= w_req & ~w_misalign & w_range_bad;
        end
    end

    assign bus.read_data    = r_data[READ_LATENCY-1];
    assign bus.read_valid   = r_valid[READ_LATENCY-1];
    assign bus.misaligned   = r_misaligned;
    assign bus.out_of_range = r_out_of_range;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: one instance with READ_LATENCY=1 for
// access/extension/fault behaviour and one with READ_LATENCY=3 for pipelining
// and mid-stream reset.
module tb_data_memory_sized;

    logic clk;
    logic rst1_n;
    logic rst3_n;

    int checkCount;
    int passCount;

    logic [31:0] l3Words [4];

    data_memory_sized_if bus1 ();
    data_memory_sized_if bus3 ();

    data_memory_sized #(.MEM_WORDS(256), .READ_LATENCY(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1)
    );

    data_memory_sized #(.MEM_WORDS(256), .READ_LATENCY(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (bus3)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // Check the three strobes of the latency-1 instance
    task automatic expectFlags(input string tag, input logic v, input logic m, input logic o);
        checkOutput({tag, " valid"}, {31'd0, bus1.read_valid}, {31'd0, v});
        checkOutput({tag, " misaligned"}, {31'd0, bus1.misaligned}, {31'd0, m});
        checkOutput({tag, " out_of_range"}, {31'd0, bus1.out_of_range}, {31'd0, o});
    endtask

    // Drive one request on the latency-1 instance, clock it, and sample just after the edge
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] sz, input logic uns);
        bus1.mem_read      = rd;
        bus1.mem_write     = wr;
        bus1.address       = addr;
        bus1.write_data    = wdata;
        bus1.size          = sz;
        bus1.load_unsigned = uns;
        @(posedge clk);
        #1;
    endtask

    // Drive one request on the latency-3 instance
    task automatic drive3(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus3.mem_read      = rd;
        bus3.mem_write     = wr;
        bus3.address       = addr;
        bus3.write_data    = wdata;
        bus3.size          = 2'b10;
        bus3.load_unsigned = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        l3Words[0] = 32'hC0DE0001;
        l3Words[1] = 32'hC0DE0002;
        l3Words[2] = 32'h8BAD0003;
        l3Words[3] = 32'h7EED0004;
        bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.address = '0;
        bus1.write_data = '0; bus1.size = 2'b00; bus1.load_unsigned = 1'b0;
        bus3.mem_read = 1'b0; bus3.mem_write = 1'b0; bus3.address = '0;
        bus3.write_data = '0; bus3.size = 2'b10; bus3.load_unsigned = 1'b0;
        rst1_n = 1'b0;
        rst3_n = 1'b0;
        #2;
        checkOutput("reset read_data", bus1.read_data, 32'h0);
        expectFlags("reset", 1'b0, 1'b0, 1'b0);
        checkOutput("reset l3 read_data", bus3.read_data, 32'h0);
        checkOutput("reset l3 valid", {31'd0, bus3.read_valid}, 32'd0);
        @(negedge clk);
        rst1_n = 1'b1;
        rst3_n = 1'b1;

        $display("[TB] word store/load and read-after-write");
        applyStimulus(1'b0, 1'b1, 32'd4, 32'h00FF00FF, 2'b10, 1'b0);
        expectFlags("store w4", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd4, 32'h0, 2'b10, 1'b0);
        expectFlags("load w4", 1'b1, 1'b0, 1'b0);
        checkOutput("load w4 data", bus1.read_data, 32'h00FF00FF);
        applyStimulus(1'b1, 1'b0, 32'd4, 32'h0, 2'b00, 1'b1);
        checkOutput("load b4 data", bus1.read_data, 32'h00000000);
        applyStimulus(1'b1, 1'b0, 32'd7, 32'h0, 2'b00, 1'b0);
        checkOutput("load b7 signed", bus1.read_data, 32'hFFFFFFFF);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'h0, 2'b00, 1'b0);
        expectFlags("idle", 1'b0, 1'b0, 1'b0);
        checkOutput("idle holds data", bus1.read_data, 32'hFFFFFFFF);

        $display("[TB] byte and half stores with extension");
        applyStimulus(1'b0, 1'b1, 32'd8, 32'h11223344, 2'b10, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'd9, 32'hABCDEF80, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd9, 32'h0, 2'b00, 1'b0);
        checkOutput("load b9 signed", bus1.read_data, 32'hFFFFFF80);
        applyStimulus(1'b1, 1'b0, 32'd9, 32'h0, 2'b00, 1'b1);
        checkOutput("load b9 unsigned", bus1.read_data, 32'h00000080);
        applyStimulus(1'b1, 1'b0, 32'd8, 32'h0, 2'b10, 1'b0);
        checkOutput("load w8 after byte", bus1.read_data, 32'h11803344);
        applyStimulus(1'b0, 1'b1, 32'd10, 32'h1234CAFE, 2'b01, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd10, 32'h0, 2'b01, 1'b0);
        checkOutput("load h10 signed", bus1.read_data, 32'hFFFFCAFE);
        applyStimulus(1'b1, 1'b0, 32'd10, 32'h0, 2'b01, 1'b1);
        checkOutput("load h10 unsigned", bus1.read_data, 32'h0000CAFE);
        applyStimulus(1'b1, 1'b0, 32'd8, 32'h0, 2'b10, 1'b0);
        checkOutput("load w8 after half", bus1.read_data, 32'h1180CAFE);

        $display("[TB] alignment faults");
        applyStimulus(1'b0, 1'b1, 32'd0, 32'h01020304, 2'b10, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd5, 32'h0, 2'b01, 1'b0);
        expectFlags("load h5", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'h0, 2'b00, 1'b0);
        expectFlags("after h5", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h402, 32'hFFFFFFFF, 2'b10, 1'b0);
        expectFlags("store w402", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h0, 2'b10, 1'b0);
        checkOutput("w0 untouched", bus1.read_data, 32'h01020304);
        applyStimulus(1'b1, 1'b0, 32'd4, 32'h0, 2'b10, 1'b0);
        checkOutput("w4 untouched", bus1.read_data, 32'h00FF00FF);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h0, 2'b11, 1'b0);
        expectFlags("reserved size", 1'b0, 1'b1, 1'b0);

        $display("[TB] range boundary");
        applyStimulus(1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 2'b10, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd1020, 32'h0, 2'b10, 1'b0);
        expectFlags("load w1020", 1'b1, 1'b0, 1'b0);
        checkOutput("load w1020 data", bus1.read_data, 32'hA5A55A5A);
        applyStimulus(1'b1, 1'b0, 32'd1021, 32'h0, 2'b10, 1'b0);
        expectFlags("load w1021", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd1023, 32'h0, 2'b00, 1'b0);
        checkOutput("load b1023 data", bus1.read_data, 32'h0000005A);
        applyStimulus(1'b1, 1'b0, 32'd1022, 32'h0, 2'b01, 1'b1);
        checkOutput("load h1022 data", bus1.read_data, 32'h00005A5A);
        applyStimulus(1'b1, 1'b0, 32'd1023, 32'h0, 2'b01, 1'b0);
        expectFlags("load h1023", 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 2'b00, 1'b0);
        expectFlags("load b1024", 1'b0, 1'b0, 1'b1);
        checkOutput("data held over faults", bus1.read_data, 32'h00005A5A);
        applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 2'b00, 1'b0);
        expectFlags("load bFFFFFFFF", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'd1024, 32'hFFFFFFFF, 2'b10, 1'b0);
        expectFlags("store w1024", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'h0, 2'b10, 1'b0);
        checkOutput("w0 not aliased", bus1.read_data, 32'h01020304);

        $display("[TB] simultaneous read and write");
        applyStimulus(1'b0, 1'b1, 32'd16, 32'h0BADF00D, 2'b10, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'd16, 32'hDEADBEEF, 2'b10, 1'b0);
        expectFlags("rd+wr w16", 1'b1, 1'b0, 1'b0);
        checkOutput("rd+wr w16 data", bus1.read_data, 32'h0BADF00D);
        applyStimulus(1'b1, 1'b0, 32'd16, 32'h0, 2'b10, 1'b0);
        checkOutput("w16 not written", bus1.read_data, 32'h0BADF00D);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'h0, 2'b00, 1'b0);

        $display("[TB] latency-3 back-to-back loads");
        for (int i = 0; i < 4; i++) begin
            drive3(1'b0, 1'b1, 32'(4 * i), l3Words[i]);
        end
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive3(1'b1, 1'b0, 32'(4 * c), 32'h0);
            else       drive3(1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("l3 valid c%0d", c), {31'd0, bus3.read_valid},
                        (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
            if (c >= 2 && c <= 5) begin
                checkOutput($sformatf("l3 data c%0d", c), bus3.read_data, l3Words[c-2]);
            end
        end
        checkOutput("l3 data held", bus3.read_data, l3Words[3]);

        $display("[TB] latency-3 reset mid-stream");
        drive3(1'b1, 1'b0, 32'd0, 32'h0);
        drive3(1'b1, 1'b0, 32'd4, 32'h0);
        bus3.mem_read = 1'b0;
        #2;
        rst3_n = 1'b0;
        #1;
        checkOutput("l3 reset data", bus3.read_data, 32'h0);
        checkOutput("l3 reset valid", {31'd0, bus3.read_valid}, 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive3(1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("l3 dropped c%0d", c), {31'd0, bus3.read_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
Byte-addressed, big-endian data memory for the single-cycle/multi-cycle datapath. It is the parametrised successor of the word-only data memory. It adds byte, halfword and word accesses, sign or zero extension on loads, a configurable read-pipeline latency with a valid strobe, and fault detection for misaligned or out-of-range accesses. It sits between the ALU address output and the register-file write-back mux.

Parameters:
MEM_WORDS, 256, memory depth in 32-bit words; byte capacity is MEM_WORDS*4.
READ_LATENCY, 1, cycles from read acceptance to read_valid; legal range 1..4.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
address  input  32  byte address of access
write_data  input  32  store data; the low 8/16/32 bits are used per size
mem_write  input  1  store request, sampled at posedge clk
mem_read  input  1  load request, sampled at posedge clk
size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as fault)
load_unsigned  input  1  1 = zero-extend, 0 = sign-extend byte/half loads
read_data  output  32  extended load result
read_valid  output  1  one-cycle pulse qualifying read_data
misaligned  output  1  one-cycle pulse: faulting access (alignment or reserved size)
out_of_range  output  1  one-cycle pulse: access beyond capacity

Behaviour:
- Reset (rst_n=0, async): read_data=0, read_valid=0, misaligned=0, out_of_range=0. All read-pipeline stages are cleared, so an in-flight load is dropped and never produces read_valid. Memory contents are not reset.
- Byte order is big-endian: byte at address is the MSB. A word at A is {m[A], m[A+1], m[A+2], m[A+3]}. A half at A is {m[A], m[A+1]}.
- One request per cycle. If mem_read and mem_write are both 1, only the read is performed and the write is ignored, with no fault.
- Alignment: a half requires address[0]=0. A word requires address[1:0]=00. size=11 is always a misaligned fault.
- Range: fault if address + nbytes - 1 >= MEM_WORDS*4, where nbytes = 1, 2 or 4. Compute in 33 bits so that address near 2^32 does not wrap.
- If both alignment and range checks fail, only misaligned is asserted.
- Faulting access: memory is not modified and no read_valid is produced. The matching fault pulse is asserted for exactly 1 cycle, in the cycle after the request edge, for both reads and writes.
- Write: at the accepting posedge, bytes A..A+nbytes-1 are updated from write_data. Byte stores use [7:0], half stores use [15:0], word stores use [31:0]. Other bytes are untouched.
- Read: memory is sampled at the accepting posedge, with size and load_unsigned captured with it. read_data and read_valid appear READ_LATENCY cycles later.
  - Byte load: {24{s&b[7]}, b}. Half load: {16{s&h[15]}, h}. Word load: passed through. Here s = !load_unsigned.
  - read_data holds its last value when read_valid=0.
- Read-after-write: a read accepted on the posedge after a write to the same address returns the new data.
- Back-to-back reads: the pipeline is fully pipelined, accepting one read per cycle and returning results in order, one per cycle.
- mem_read=mem_write=0: no access and no pulses.

Test Plan:
- Word store 0x00FF00FF at address 4, then word load at 4 (READ_LATENCY=1) -> read_valid pulses 1 cycle after the load edge with read_data=0x00FF00FF. m[4]=0x00, m[7]=0xFF.
- Byte store 0x80 at address 9, then load byte at 9 signed -> 0xFFFFFF80; unsigned -> 0x00000080. Word at 8 shows only byte 1 changed.
- Half load at address 5 -> misaligned=1 for 1 cycle, no read_valid. Word store at 0x402 -> misaligned, memory unchanged.
- Word load at 1020 (MEM_WORDS=256) -> valid. Word load at 1021 -> misaligned only. Byte load at 1024 -> out_of_range. Address 0xFFFFFFFF byte load -> out_of_range.
- READ_LATENCY=3: four back-to-back loads at 0, 4, 8, 12 -> four consecutive read_valid pulses starting 3 cycles after the first, data in order. Assert rst_n=0 mid-stream -> outputs 0 immediately and no further read_valid.
- mem_read=mem_write=1 at address 16 with write_data=0xDEADBEEF -> old word returned and a later load confirms no write occurred.
